// File: rtl/dut_cfg_chain_emu.sv
// Purpose : emulates a DUT configuration shift chain with two shadow banks, driven from async FW pins.
// Latency : a pin edge acts on the 3rd fw_clk edge after it changes; fw_config_out follows one edge later.
// Backpr. : none; the FW side must hold each fw_config_clk phase for at least 3 fw_clk cycles.
//
// Ports:
//   fw_clk, fw_rst           sole clock, async active-high reset
//   fw_config_clk/in         serial shift clock and data (async to fw_clk)
//   fw_config_load           rising edge copies the chain into the bank picked by fw_super_pixel_sel
//   fw_reset_not             emulated DUT reset, active-low; holds all state at 0
//   fw_config_out            registered copy of the chain's last bit
//   cfg_bank0/1              shadow bank contents
//   cfg_load_pulse           one-cycle strobe after a bank update
//   shift_count, len_err     shift edges since last load; sticky wrong-length-load flag
// Build option: define CFG_EMU_LEN_CHECK_EN to build shift_count/len_err, otherwise both read 0.
module dut_cfg_chain_emu #(
   parameter int CHAIN_LEN = 256
) (
   input  logic                 fw_clk,
   input  logic                 fw_rst,
   input  logic                 fw_config_clk,
   input  logic                 fw_config_in,
   input  logic                 fw_config_load,
   input  logic                 fw_super_pixel_sel,
   input  logic                 fw_reset_not,
   output logic                 fw_config_out,
   output logic [CHAIN_LEN-1:0] cfg_bank0,
   output logic [CHAIN_LEN-1:0] cfg_bank1,
   output logic                 cfg_load_pulse,
   output logic [15:0]          shift_count,
   output logic                 len_err
);

   // Bit positions of each pin in the synchronizer vectors.
   localparam int PIN_CLK  = 4;
   localparam int PIN_LOAD = 3;
   localparam int PIN_IN   = 2;
   localparam int PIN_SEL  = 1;
   localparam int PIN_RSTN = 0;

   logic [4:0]           pins;
   logic [4:0]           sync1;
   logic [4:0]           sync2;
   logic [4:0]           hist;
   logic [1:0]           fill;     // [1] set once sync2 holds a real pin sample
   logic [1:0]           armed;    // [1] config clk, [0] load: a valid low level has been seen
   logic                 shift_ev;
   logic                 load_ev;
   logic                 in_s;
   logic                 sel_s;
   logic                 run;
   logic [CHAIN_LEN-1:0] shift_reg;
   logic [CHAIN_LEN-1:0] shift_next;
   logic                 unused_hist;

   assign pins = {fw_config_clk, fw_config_load, fw_config_in, fw_super_pixel_sel, fw_reset_not};

   // Identical 2-flop synchronizer plus history flop on every pin. History keeps tracking
   // during emulated reset, so releasing fw_reset_not never fabricates an edge.
   always_ff @(posedge fw_clk or posedge fw_rst) begin
      if (fw_rst) begin
         sync1 <= '0;
         sync2 <= '0;
         hist  <= '0;
         fill  <= '0;
         armed <= '0;
      end else begin
         sync1 <= pins;
         sync2 <= sync1;
         hist  <= sync2;
         fill  <= {fill[0], 1'b1};
         // The zeros left by fw_rst are not real samples; a pin high at reset release
         // must first be observed low before its rising edge counts.
         armed <= armed | ({2{fill[1]}} & ~{sync2[PIN_CLK], sync2[PIN_LOAD]});
      end
   end

   assign shift_ev = sync2[PIN_CLK]  & ~hist[PIN_CLK]  & armed[1];
   assign load_ev  = sync2[PIN_LOAD] & ~hist[PIN_LOAD] & armed[0];
   assign in_s     = sync2[PIN_IN];
   assign sel_s    = sync2[PIN_SEL];
   assign run      = sync2[PIN_RSTN];

   // Level-only pins keep their history flop for uniformity; nothing consumes it.
   assign unused_hist = ^hist[PIN_IN:PIN_RSTN];

   // Shift first so a same-cycle load captures the post-shift chain.
   assign shift_next = shift_ev ? {shift_reg[CHAIN_LEN-2:0], in_s} : shift_reg;

   always_ff @(posedge fw_clk or posedge fw_rst) begin
      if (fw_rst) begin
         shift_reg      <= '0;
         cfg_bank0      <= '0;
         cfg_bank1      <= '0;
         cfg_load_pulse <= 1'b0;
         fw_config_out  <= 1'b0;
      end else if (!run) begin
         shift_reg      <= '0;
         cfg_bank0      <= '0;
         cfg_bank1      <= '0;
         cfg_load_pulse <= 1'b0;
         fw_config_out  <= 1'b0;
      end else begin
         shift_reg      <= shift_next;
         fw_config_out  <= shift_reg[CHAIN_LEN-1];
         cfg_load_pulse <= load_ev;
         if (load_ev) begin
            if (sel_s) begin
               cfg_bank1 <= shift_next;
            end else begin
               cfg_bank0 <= shift_next;
            end
         end
      end
   end

`ifdef CFG_EMU_LEN_CHECK_EN
   logic [15:0] cnt_q;
   logic [15:0] cnt_pre;   // count including any shift in this cycle
   logic        err_q;

   always_comb begin
      cnt_pre = cnt_q;
      if (shift_ev && (cnt_q != 16'hFFFF)) begin
         cnt_pre = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge fw_clk or posedge fw_rst) begin
      if (fw_rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (!run) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (load_ev) begin
         cnt_q <= {15'd0, shift_ev};
         if (cnt_pre != 16'(CHAIN_LEN)) begin
            err_q <= 1'b1;
         end
      end else begin
         cnt_q <= cnt_pre;
      end
   end

   assign shift_count = cnt_q;
   assign len_err     = err_q;
`else
   assign shift_count = '0;
   assign len_err     = 1'b0;
`endif

endmodule

// File: doc/dut_cfg_chain_emu.md
DUT_CFG_CHAIN_EMU -- requirements
Module: dut_cfg_chain_emu

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 256, which sets the number of config shift-chain bits (range 2..4096).
REQ-002 fw_clk  input  1  sole clock; all state SHALL be clocked on its rising edge.
REQ-003 fw_rst  input  1  reset, asynchronous and active-high.
REQ-004 fw_config_clk  input  1  DUT config shift clock driven by the FW side; asynchronous to fw_clk.
REQ-005 fw_config_in  input  1  config serial data, sampled on the fw_config_clk rising edge.
REQ-006 fw_config_load  input  1  rising edge transfers the shift chain into the selected shadow bank.
REQ-007 fw_super_pixel_sel  input  1  shadow bank select sampled at load: 0 selects bank0, 1 selects bank1.
REQ-008 fw_reset_not  input  1  emulated DUT reset, active-low.
REQ-009 fw_config_out  output  1  serial output, registered copy of shift-chain bit CHAIN_LEN-1.
REQ-010 cfg_bank0, cfg_bank1  output  CHAIN_LEN each  shadow register contents.
REQ-011 cfg_load_pulse  output  1  single-cycle strobe marking a completed load.
REQ-012 shift_count  output  16  shift edges seen since the last load.
REQ-013 len_err  output  1  sticky flag: a load occurred with shift_count != CHAIN_LEN.

Function
REQ-014 Each of fw_config_clk, fw_config_in, fw_config_load, fw_super_pixel_sel and fw_reset_not SHALL pass through an identical 2-flop synchronizer, followed by one history flop for edge detection.
REQ-015 A synchronized fw_config_clk rising edge SHALL update shift_reg to {shift_reg[CHAIN_LEN-2:0], synchronized fw_config_in} on the 3rd fw_clk edge after the pin change, counting the first sampling edge as 1.
REQ-016 fw_config_out SHALL follow shift_reg[CHAIN_LEN-1] one fw_clk cycle later (4th edge).
REQ-017 fw_config_clk falling edges SHALL have no effect; correct operation requires each of its high and low phases to last at least 3 fw_clk cycles.
REQ-018 A synchronized fw_config_load rising edge SHALL copy shift_reg into the bank chosen by synchronized fw_super_pixel_sel and leave the other bank unchanged.
REQ-019 cfg_load_pulse SHALL be high for exactly the one cycle after the bank update; a held-high fw_config_load SHALL NOT re-trigger.
REQ-020 When a shift edge and a load edge are detected in the same cycle, the shift SHALL apply first and the bank SHALL capture the post-shift value.
REQ-021 Each shift edge SHALL increment shift_count, saturating at 16'hFFFF.
REQ-022 A load SHALL clear shift_count to 0, or to 1 if a shift occurs in the same cycle.
REQ-023 A load with pre-load count (including any same-cycle shift) != CHAIN_LEN SHALL set len_err; len_err SHALL clear only on reset.
REQ-024 While synchronized fw_reset_not is 0, shift_reg, both banks, shift_count, len_err, cfg_load_pulse and fw_config_out SHALL be held at 0, and shift and load edges SHALL be ignored.
REQ-025 After fw_reset_not returns high, edge detection SHALL resume without a spurious edge: history flops track the synchronized level during emulated reset.

Reset
REQ-026 fw_rst asserted SHALL immediately force all synchronizer, history and state flops and all outputs to 0.
REQ-027 After fw_rst deasserts, a pin already high SHALL NOT produce an edge until it has been seen low first.

Configuration
REQ-028 Macro CFG_EMU_LEN_CHECK_EN defined: shift_count and len_err SHALL be implemented per REQ-021..REQ-023.
REQ-029 Macro CFG_EMU_LEN_CHECK_EN undefined: no counter logic SHALL be built, and shift_count and len_err SHALL be tied to 0; all other behaviour SHALL be unchanged.

Verification (bench CHAIN_LEN=8, fw_config_clk phases 4 cycles, macro defined unless noted)
REQ-030 Shift 8'hA5 MSB-first, pulse load with sel=0 -> cfg_bank0=8'hA5, cfg_bank1=0, one-cycle cfg_load_pulse, len_err=0, shift_count=0.
REQ-031 Then shift 8'h3C with sel=1 and load -> cfg_bank1=8'h3C, cfg_bank0 stays 8'hA5; during the shift, fw_config_out emits 1,0,1,0,0,1,0,1 (prior chain contents).
REQ-032 Shift 5 bits then load -> len_err=1 and stays 1 through later correct 8-bit loads until fw_rst.
REQ-033 Drive the load and shift rising edges on the same fw_clk edge -> bank gets the post-shift value, shift_count=1.
REQ-034 Pull fw_reset_not low mid-shift for 6 cycles -> all outputs 0; after release, an 8-bit shift of 8'hFF and load gives cfg_bank0=8'hFF with no extra shift.
REQ-035 Assert fw_rst while fw_config_load is held high, then release -> no cfg_load_pulse; with the macro undefined, shift_count=0 and len_err=0 throughout.
